// File: rtl/store_narrow_if.sv
// store_narrow_if
//   Bundles the store request/response handshake and the word-wide data RAM
//   port used by store_narrow_unit.
//   Request side : req_valid/req_ready, req_addr (byte address), req_data,
//                  req_size (00 byte, 01 half, 10 word, 11 illegal),
//                  done/addr_err completion pulses.
//   Memory side  : mem_addr (word address), mem_rd/mem_rdata/mem_rvalid,
//                  mem_wr/mem_wdata/mem_wack.
//   Modports     : slave  = the store unit
//                  master = MEM-stage control plus RAM (the environment)
interface store_narrow_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              done;
  logic              addr_err;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic              mem_wack;

  modport slave (
    input  req_valid, req_addr, req_data, req_size,
    input  mem_rdata, mem_rvalid, mem_wack,
    output req_ready, done, addr_err,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_data, req_size,
    output mem_rdata, mem_rvalid, mem_wack,
    input  req_ready, done, addr_err,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/store_narrow_unit.sv
// store_narrow_unit
//   Narrows a 32-bit GPR value to byte/half/word and stores it into a
//   word-wide RAM with no byte enables. Word stores write directly; sub-word
//   stores read the word, splice the new lane(s) in, and write it back.
//   Misaligned or illegal-size requests complete at once with addr_err and
//   touch no memory.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any operation, drops strobes)
//   bus   : store_narrow_if.slave (request handshake + RAM port)
module store_narrow_unit #(
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  store_narrow_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_FIN,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;   // only the low half is ever spliced in
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;  // holds read word, then merged / word data
  logic [31:0]       merged;
  logic              accept;
  logic              bad;

  assign accept = bus.req_valid && (state_q == S_IDLE);

  // Illegal size, or a half/word not naturally aligned.
  assign bad = (bus.req_size == 2'b11) ||
               ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

  // Replace only the addressed lane(s); every other bit of the read word
  // passes through untouched.
  always_comb begin
    merged = wdata_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = data_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = data_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.done      = 1'b0;
    bus.addr_err  = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (bad)                        state_d = S_ERR;
          else if (bus.req_size == 2'b10) state_d = S_WR;
          else                            state_d = S_RD;
        end
      end
      S_RD: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_rvalid) state_d = S_MERGE;
      end
      S_MERGE: state_d = S_WR;
      S_WR: begin
        bus.mem_wr = 1'b1;
        if (bus.mem_wack) state_d = S_FIN;
      end
      S_FIN: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        bus.done     = 1'b1;
        bus.addr_err = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          addr_q <= bus.req_addr;
          data_q <= bus.req_data[15:0];
          size_q <= bus.req_size;
          // Word stores skip the read, so the write word is loaded here.
          if (!bad && bus.req_size == 2'b10) wdata_q <= bus.req_data;
        end
        S_RD:    if (bus.mem_rvalid) wdata_q <= bus.mem_rdata;
        S_MERGE: wdata_q <= merged;
        default: ;
      endcase
    end
  end

  // Address is latched at accept, so it stays constant across RD and WR.
  assign bus.mem_addr  = addr_q[ADDR_W-1:2];
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit
//   Directed bench for store_narrow_unit. A small RAM model answers mem_rd /
//   mem_wr with programmable latency; each scenario task drives a store and
//   checks latency, written word and strobe activity against hand-computed
//   values.
module tb_store_narrow_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_narrow_if #(.ADDR_W(32)) bus ();
  store_narrow_unit #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [31:0] ram [0:63];
  int rd_lat = 0, wr_lat = 0;
  int rd_cyc = 0, wr_cyc = 0, wr_cnt = 0, done_cnt = 0, both_hi = 0;
  logic [29:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  // RAM responder and activity monitor, evaluated on the falling edge.
  always @(negedge clk) begin : resp
    int rc, wc;
    if (bus.mem_rd && bus.mem_wr) both_hi++;
    if (bus.done) done_cnt++;
    if (bus.mem_rd) begin
      rd_cyc++;
      bus.mem_rvalid = (rc >= rd_lat);
      bus.mem_rdata  = ram[bus.mem_addr[5:0]];
      rc++;
    end else begin
      rc = 0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hxxxx_xxxx;
    end
    if (bus.mem_wr) begin
      wr_cyc++;
      bus.mem_wack = (wc >= wr_lat);
      if (bus.mem_wack) begin
        ram[bus.mem_addr[5:0]] = bus.mem_wdata;
        last_waddr = bus.mem_addr;
        last_wdata = bus.mem_wdata;
        wr_cnt++;
      end
      wc++;
    end else begin
      wc = 0;
      bus.mem_wack = 1'b0;
    end
  end

  // Drive one store; report done cycle (accept edge = cycle 0), error flag,
  // whether req_ready stayed low while busy, and req_ready after done.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input bit poke,
                           output int dcyc, output bit derr,
                           output bit busy_low, output bit ready_after);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
    dcyc = -1; derr = 1'b0; busy_low = 1'b1;
    for (int c = 1; c <= 60 && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (poke && c == 2) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h40;
        bus.req_data  = 32'hFFFF_FFFF;
        bus.req_size  = 2'b10;
      end
      if (poke && c == 4) bus.req_valid = 1'b0;
      if (bus.done) begin
        dcyc = c;
        derr = bus.addr_err;
      end else if (bus.req_ready) busy_low = 1'b0;
    end
    @(negedge clk);
    #1 ready_after = bus.req_ready && !bus.done;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_size = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.done !== 1'b0 || bus.addr_err !== 1'b0 ||
        bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 30'd0 ||
        bus.mem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b done=%b err=%b rd=%b wr=%b addr=%h wd=%h, want 1 0 0 0 0 0 0",
               bus.req_ready, bus.done, bus.addr_err, bus.mem_rd, bus.mem_wr,
               bus.mem_addr, bus.mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    int dc, r0, w0; bit er, bl, ra;
    r0 = rd_cyc; w0 = wr_cnt;
    run_store(32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, dc, er, bl, ra);
    tests++;
    if (dc !== 2 || er !== 1'b0) begin
      fails++; $display("FAIL sw_latency: got done@%0d err=%b, want done@2 err=0", dc, er);
    end
    tests++;
    if (last_waddr !== 30'h4 || last_wdata !== 32'hDEAD_BEEF || wr_cnt - w0 != 1) begin
      fails++; $display("FAIL sw_write: got addr=%h data=%h n=%0d, want 4 deadbeef 1", last_waddr, last_wdata, wr_cnt - w0);
    end
    tests++;
    if (rd_cyc != r0 || !bl || !ra) begin
      fails++; $display("FAIL sw_handshake: got rdcyc=%0d busy_low=%b ready_after=%b, want 0 1 1", rd_cyc - r0, bl, ra);
    end
  endtask

  task automatic test_byte();
    int dc; bit er, bl, ra;
    ram[4] = 32'h1122_3344;
    run_store(32'h13, 32'h1234_56AB, 2'b00, 1'b0, dc, er, bl, ra);
    tests++;
    if (dc !== 4 || er !== 1'b0 || !ra) begin
      fails++; $display("FAIL sb_latency: got done@%0d err=%b ready_after=%b, want done@4 0 1", dc, er, ra);
    end
    tests++;
    if (last_waddr !== 30'h4 || last_wdata !== 32'hAB22_3344) begin
      fails++; $display("FAIL sb_lane3: got addr=%h data=%h, want 4 ab223344", last_waddr, last_wdata);
    end
    ram[5] = 32'h1122_3344;
    run_store(32'h14, 32'hFFFF_FF99, 2'b00, 1'b0, dc, er, bl, ra);
    tests++;
    if (last_waddr !== 30'h5 || last_wdata !== 32'h1122_3399) begin
      fails++; $display("FAIL sb_lane0: got addr=%h data=%h, want 5 11223399", last_waddr, last_wdata);
    end
  endtask

  task automatic test_half();
    int dc; bit er, bl, ra;
    ram[8] = 32'hAAAA_BBBB;
    run_store(32'h22, 32'hFFFF_8001, 2'b01, 1'b0, dc, er, bl, ra);
    tests++;
    if (dc !== 4 || last_waddr !== 30'h8 || last_wdata !== 32'h8001_BBBB) begin
      fails++; $display("FAIL sh_upper: got done@%0d addr=%h data=%h, want 4 8 8001bbbb", dc, last_waddr, last_wdata);
    end
    ram[8] = 32'hAAAA_BBBB;
    run_store(32'h20, 32'hFFFF_8001, 2'b01, 1'b0, dc, er, bl, ra);
    tests++;
    if (dc !== 4 || last_wdata !== 32'hAAAA_8001) begin
      fails++; $display("FAIL sh_lower: got done@%0d data=%h, want 4 aaaa8001", dc, last_wdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] av [3] = '{32'h21, 32'h22, 32'h20};
    logic [1:0]  sv [3] = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      int dc, r0, w0; bit er, bl, ra;
      r0 = rd_cyc; w0 = wr_cyc;
      run_store(av[i], 32'h5555_5555, sv[i], 1'b0, dc, er, bl, ra);
      tests++;
      if (dc !== 1 || er !== 1'b1 || rd_cyc != r0 || wr_cyc != w0 || !ra) begin
        fails++;
        $display("FAIL err_case%0d: got done@%0d err=%b rdcyc=%0d wrcyc=%0d ready_after=%b, want 1 1 0 0 1",
                 i, dc, er, rd_cyc - r0, wr_cyc - w0, ra);
      end
    end
  endtask

  task automatic test_wait_states();
    int dc, r0, w0, d0, n0; bit er, bl, ra;
    ram[12] = 32'h0102_0304;
    ram[16] = 32'h0000_0000;
    rd_lat = 3; wr_lat = 2;
    r0 = rd_cyc; w0 = wr_cyc; d0 = done_cnt; n0 = wr_cnt;
    run_store(32'h31, 32'h0000_005A, 2'b00, 1'b1, dc, er, bl, ra);
    rd_lat = 0; wr_lat = 0;
    tests++;
    if (dc !== 9 || rd_cyc - r0 != 4 || wr_cyc - w0 != 3) begin
      fails++; $display("FAIL ws_timing: got done@%0d rdcyc=%0d wrcyc=%0d, want 9 4 3", dc, rd_cyc - r0, wr_cyc - w0);
    end
    tests++;
    if (last_wdata !== 32'h0102_5A04 || ram[16] !== 32'h0 || wr_cnt - n0 != 1) begin
      fails++; $display("FAIL ws_data: got data=%h ram16=%h writes=%0d, want 01025a04 0 1", last_wdata, ram[16], wr_cnt - n0);
    end
    tests++;
    if (done_cnt - d0 != 1 || !bl || !ra) begin
      fails++; $display("FAIL ws_handshake: got dones=%0d busy_low=%b ready_after=%b, want 1 1 1", done_cnt - d0, bl, ra);
    end
  endtask

  task automatic test_reset_mid_write();
    int dc; bit er, bl, ra, seen;
    ram[20] = 32'hFFFF_FFFF;
    wr_lat = 10;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h52; bus.req_data = 32'hC3; bus.req_size = 2'b00;
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.mem_wr) seen = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL rst_reach_wr: got mem_wr=0 after 20 cycles, want 1");
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.mem_wr !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_rd !== 1'b0) begin
      fails++; $display("FAIL rst_abort: got wr=%b rd=%b rdy=%b, want 0 0 1", bus.mem_wr, bus.mem_rd, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_lat = 0;
    tests++;
    if (ram[20] !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL rst_no_write: got ram20=%h, want ffffffff", ram[20]);
    end
    run_store(32'h52, 32'h0000_0077, 2'b00, 1'b0, dc, er, bl, ra);
    tests++;
    if (dc !== 4 || er !== 1'b0 || last_wdata !== 32'hFF77_FFFF) begin
      fails++; $display("FAIL rst_recover: got done@%0d err=%b data=%h, want 4 0 ff77ffff", dc, er, last_wdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    bus.mem_rvalid = 1'b0; bus.mem_wack = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_wait_states();
    test_reset_mid_write();
    tests++;
    if (both_hi != 0) begin
      fails++; $display("FAIL strobe_exclusive: got %0d cycles with rd&wr, want 0", both_hi);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
